uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 8, byte buffer depth; power of two, 2..64.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  byte to transmit.
REQ-007 tx_valid  input  1  tx_data is valid this cycle.
REQ-008 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 TxD  output  1  serial line, 8N1, idle high.
REQ-010 busy  output  1  a frame is on the line or the FIFO is non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-012 Bit period DIV = CLK_HZ/BAUD, integer-truncated (434 at defaults); every bit, including start and stop, lasts exactly DIV cycles.
REQ-013 A byte is accepted on a rising edge where tx_valid && tx_ready; tx_data is ignored otherwise.
REQ-014 tx_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
REQ-015 Simultaneous push and pop in the same cycle: both take effect and fifo_count is unchanged.
REQ-016 When full, tx_ready is low, tx_valid is ignored, and no data is overwritten or dropped.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: TxD=1; when fifo_count>0, pop head into the shift register and enter START on the same edge.
REQ-019 START: TxD=0 for DIV cycles, then DATA with bit index 0.
REQ-020 DATA: TxD = shift bit, LSB first; after DIV cycles, advance the index; after bit 7, go to STOP.
REQ-021 STOP: TxD=1 for DIV cycles; on the final cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap), else go to IDLE.
REQ-022 Latency: a byte accepted into an empty FIFO with the FSM in IDLE at edge k gives a TxD falling edge after edge k+2.
REQ-023 Frame length: exactly 10*DIV cycles (4340 at defaults); back-to-back frames have no extra cycles between them.
REQ-024 TxD is driven from a flop, so it is glitch-free.
REQ-025 The baud counter counts 0..DIV-1 and wraps; it resets to 0 on every state entry.
REQ-026 busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-027 While rst is high at a rising edge: TxD=1, state=IDLE, FIFO emptied (fifo_count=0), read/write pointers=0, baud counter=0, bit index=0, tx_ready=1, busy=0.
REQ-028 Reset mid-frame aborts the frame: TxD is high after that edge, no partial byte is resumed, and buffered bytes are discarded.
REQ-029 A push in a cycle where rst is high is ignored.

Structure
REQ-030 Shared package uart_pkg holds the state encoding (IDLE, START, DATA, STOP) and the DIV calculation function, for reuse by the existing receiver.
REQ-031 The FIFO is a sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty), with first-word fall-through output.

Verification
REQ-032 After reset, push 8'h01 once -> TxD low 2 cycles later; sampled mid-bit pattern 0,1,0,0,0,0,0,0,0,1; busy is low 4340 cycles after the start bit.
REQ-033 Push 8'hA5 then 8'h3C back-to-back -> two frames, 8680 contiguous cycles, stop bit of the first immediately followed by start bit of the second.
REQ-034 Hold tx_valid high with 10 distinct bytes while the line is idle -> tx_ready drops when fifo_count=8; all accepted bytes are transmitted in order with none lost or duplicated.
REQ-035 Push on the same edge as the STOP-state pop with fifo_count=3 -> fifo_count stays 3.
REQ-036 Assert rst during DATA bit 4 of 8'hFF with 3 bytes queued -> TxD=1 and fifo_count=0 the next cycle; no further start bit until a new push.
REQ-037 Loopback TxD into the existing UART receiver at defaults, sending 8'h01 and 8'h03 -> the receiver reports 8'h01 then 8'h03.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and
// bit-period divider calculation, shared by TX and RX.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word fall-through.
// Power-of-two depth, pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CAP);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // storage write; pushes during reset are dropped
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr] <= din;
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PONE;
      if (w_pop)  r_rd <= r_rd + PONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. TxD is a
// flop lagging the FSM state by one cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        TxD,
  output logic        busy,
  output logic [AW:0] fifo_count
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [AW:0]   CAP  = (AW+1)'(FIFO_DEPTH);

  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_last;
  logic          w_push;
  logic          w_pop;

  assign w_last   = (r_cnt == LAST);
  assign tx_ready = (fifo_count < CAP);
  assign w_push   = tx_valid && !w_full;
  assign w_pop    = !w_empty &&
                    ((r_state == IDLE) ||
                     (r_state == STOP && w_last));
  assign TxD      = r_txd;
  assign busy     = (r_state != IDLE) ||
                    (fifo_count != '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // frame sequencer with registered line output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          r_cnt <= '0;
          if (!w_empty) begin
            r_shift <= w_head;
            r_state <= START;
          end
        end
        START: begin
          r_txd <= 1'b0;
          if (w_last) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + CONE;
          end
        end
        DATA: begin
          r_txd <= r_shift[r_idx];
          if (w_last) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CONE;
          end
        end
        STOP: begin
          r_txd <= 1'b1;
          if (w_last) begin
            r_cnt <= '0;
            if (!w_empty) begin
              r_shift <= w_head;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=16,
// with a bench-side mid-bit serial decoder.
module tb_uart_tx_fifo;

  localparam int DIV = 16;
  localparam int FR  = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       TxD;
  logic       busy;
  logic [3:0] fifo_count;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  uart_tx_fifo #(
    .CLK_HZ     (1600),
    .BAUD       (100),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .TxD        (TxD),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push1(input logic [7:0] b,
                       output int k);
    tx_data = b;
    tx_valid = 1'b1;
    tick();
    k = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_start(input int bound,
                            output bit ok,
                            output int t);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < bound; i++) begin
      if (TxD === 1'b0) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic rx_frame(output logic [7:0] b,
                          output logic [9:0] bits);
    repeat (DIV / 2) tick();
    bits[0] = TxD;
    for (int i = 1; i < 10; i++) begin
      repeat (DIV) tick();
      bits[i] = TxD;
    end
    b = bits[8:1];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    tick();
    tick();
    n_checks++;
    if (TxD !== 1'b1)
      $display("FAIL reset_txd got %b want 1", TxD);
    else n_pass++;
    n_checks++;
    if (tx_ready !== 1'b1)
      $display("FAIL reset_ready got %b want 1",
               tx_ready);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (fifo_count !== 4'd0)
      $display("FAIL reset_count got %0d want 0",
               fifo_count);
    else n_pass++;
    rst = 1'b0;
    tx_valid = 1'b0;
    tick();
    n_checks++;
    if (fifo_count !== 4'd0 || TxD !== 1'b1)
      $display("FAIL reset_push_ignored cnt %0d txd %b want 0 1",
               fifo_count, TxD);
    else n_pass++;
  endtask

  task automatic test_single();
    int k, t;
    bit ok;
    logic [7:0] b;
    logic [9:0] bits;
    do_reset();
    push1(8'h01, k);
    n_checks++;
    if (fifo_count !== 4'd1)
      $display("FAIL single_count got %0d want 1",
               fifo_count);
    else n_pass++;
    wait_start(4 * FR, ok, t);
    n_checks++;
    if (!ok || t - k != 2)
      $display("FAIL single_latency got %0d want 2",
               t - k);
    else n_pass++;
    rx_frame(b, bits);
    n_checks++;
    if (bits !== 10'b10_0000_0010)
      $display("FAIL single_pattern got %b want %b",
               bits, 10'b10_0000_0010);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL single_busy_stop got %b want 1",
               busy);
    else n_pass++;
    repeat (DIV / 2) tick();
    n_checks++;
    if (busy !== 1'b0 || cyc - t != FR)
      $display("FAIL single_busy_end got %b want 0 at %0d",
               busy, cyc - t);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    bit ok1, ok2;
    logic [7:0] b1, b2;
    logic [9:0] s1, s2;
    do_reset();
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'h3C;
    tick();
    tx_valid = 1'b0;
    wait_start(4 * FR, ok1, t1);
    rx_frame(b1, s1);
    wait_start(4 * FR, ok2, t2);
    rx_frame(b2, s2);
    n_checks++;
    if (!ok1 || b1 !== 8'hA5 || s1[9] !== 1'b1)
      $display("FAIL b2b_first got %h want a5", b1);
    else n_pass++;
    n_checks++;
    if (!ok2 || b2 !== 8'h3C || s2[9] !== 1'b1)
      $display("FAIL b2b_second got %h want 3c", b2);
    else n_pass++;
    n_checks++;
    if (t2 - t1 != FR)
      $display("FAIL b2b_gap got %0d want %0d",
               t2 - t1, FR);
    else n_pass++;
    repeat (DIV / 2) tick();
    n_checks++;
    if (busy !== 1'b0 || cyc - t1 != 2 * FR)
      $display("FAIL b2b_end busy %b span %0d want 0 %0d",
               busy, cyc - t1, 2 * FR);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [7:0] src [10];
    logic [7:0] got [$];
    int j;
    bit seen_full;
    bit stuck;
    for (int i = 0; i < 10; i++)
      src[i] = 8'(8'h21 + 8'(i * 17));
    do_reset();
    j = 0;
    seen_full = 1'b0;
    stuck = 1'b0;
    fork
      begin
        for (int c = 0; c < 8 * FR && j < 10; c++) begin
          tx_data = src[j];
          tx_valid = 1'b1;
          if (fifo_count == 4'd8 && !seen_full) begin
            seen_full = 1'b1;
            n_checks++;
            if (tx_ready !== 1'b0)
              $display("FAIL full_ready got %b want 0",
                       tx_ready);
            else n_pass++;
          end
          if (tx_ready === 1'b1) begin
            tick();
            j++;
          end else begin
            tick();
          end
        end
        tx_valid = 1'b0;
        if (j < 10) stuck = 1'b1;
      end
      begin
        for (int n = 0; n < 10; n++) begin
          int t;
          bit ok;
          logic [7:0] b;
          logic [9:0] s;
          wait_start(4 * FR, ok, t);
          if (!ok) break;
          rx_frame(b, s);
          got.push_back(b);
        end
      end
    join
    n_checks++;
    if (!seen_full || stuck)
      $display("FAIL full_seen seen %b stuck %b want 1 0",
               seen_full, stuck);
    else n_pass++;
    n_checks++;
    if (got.size() != 10)
      $display("FAIL full_frames got %0d want 10",
               got.size());
    else n_pass++;
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== src[i])
        $display("FAIL full_order[%0d] got %h want %h",
                 i, got[i], src[i]);
      else n_pass++;
    end
  endtask

  task automatic test_simul();
    int k, kd, s, t;
    bit ok;
    do_reset();
    push1(8'h11, k);
    push1(8'h22, kd);
    push1(8'h33, kd);
    push1(8'h44, kd);
    s = k + 2;
    n_checks++;
    if (fifo_count !== 4'd3)
      $display("FAIL simul_pre got %0d want 3",
               fifo_count);
    else n_pass++;
    while (cyc < s + FR - 2) tick();
    tx_data = 8'h55;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 4'd3)
      $display("FAIL simul_count got %0d want 3",
               fifo_count);
    else n_pass++;
    wait_start(4 * FR, ok, t);
    n_checks++;
    if (!ok || t - s != FR)
      $display("FAIL simul_next got %0d want %0d",
               t - s, FR);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k, kd, s, lows;
    do_reset();
    push1(8'hFF, k);
    push1(8'h01, kd);
    push1(8'h02, kd);
    push1(8'h03, kd);
    s = k + 2;
    while (cyc < s + DIV + 4 * DIV + DIV / 2) tick();
    n_checks++;
    if (TxD !== 1'b1 || fifo_count !== 4'd3)
      $display("FAIL mid_bit4 txd %b cnt %0d want 1 3",
               TxD, fifo_count);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (TxD !== 1'b1 || fifo_count !== 4'd0)
      $display("FAIL mid_reset txd %b cnt %0d want 1 0",
               TxD, fifo_count);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1)
      $display("FAIL mid_flags busy %b rdy %b want 0 1",
               busy, tx_ready);
    else n_pass++;
    lows = 0;
    repeat (4 * FR) begin
      tick();
      if (TxD !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0)
      $display("FAIL mid_quiet got %0d low cycles want 0",
               lows);
    else n_pass++;
  endtask

  task automatic test_loopback();
    int k, t;
    bit ok;
    logic [7:0] b;
    logic [9:0] s;
    do_reset();
    push1(8'h01, k);
    wait_start(4 * FR, ok, t);
    rx_frame(b, s);
    n_checks++;
    if (!ok || b !== 8'h01)
      $display("FAIL loop_first got %h want 01", b);
    else n_pass++;
    repeat (DIV) tick();
    push1(8'h03, k);
    wait_start(4 * FR, ok, t);
    rx_frame(b, s);
    n_checks++;
    if (!ok || b !== 8'h03)
      $display("FAIL loop_second got %h want 03", b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_simul();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
